// File: rtl/lion_gate_emitter_if.sv
// Command/gate bundle between a lion-command source and the gate emitter.
// The master side issues commands; the slave side (the emitter) produces the gate waveform.
interface lion_gate_emitter_if;
  logic       cmd_valid;
  logic       cmd_dir;
  logic       cmd_ready;
  logic       g_one;
  logic       g_two;
  logic       busy;
  logic       done;
  logic [3:0] occupancy;

  modport master (
    output cmd_valid, cmd_dir,
    input  cmd_ready, g_one, g_two, busy, done, occupancy
  );

  modport slave (
    input  cmd_valid, cmd_dir,
    output cmd_ready, g_one, g_two, busy, done, occupancy
  );
endinterface

// File: rtl/lion_gate_emitter.sv
// Turns enter/exit commands into the two-gate light-beam waveform for the lion-cage counter,
// keeping a 4-bit mirror of the count the counter is expected to show.
module lion_gate_emitter #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned GAP   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  lion_gate_emitter_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PH1  = 3'd1,
    S_PH2  = 3'd2,
    S_PH3  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);

  state_t      state_r;
  logic [7:0]  timer_r;
  logic        dir_r;
  logic        g_one_r;
  logic        g_two_r;
  logic        busy_r;
  logic        done_r;
  logic [3:0]  occ_r;
  logic        phase_end_s;

  // Gate levels {g_one, g_two} for a phase; dir=1 is an exit, which mirrors the enter pattern.
  function automatic logic [1:0] gates(input state_t s, input logic dir);
    logic [1:0] g;
    case (s)
      S_PH1:   g = dir ? 2'b01 : 2'b10;
      S_PH2:   g = 2'b11;
      S_PH3:   g = dir ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

  // Phase-end detection: the timer counts 0..LEN-1 in every non-idle state.
  always_comb begin
    phase_end_s = 1'b0;
    if (state_r == S_GAP) begin
      phase_end_s = (timer_r == GAP_LAST);
    end else begin
      phase_end_s = (timer_r == DWELL_LAST);
    end
  end

  // Sequencer: state, timer, registered gate levels, status and occupancy mirror.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      timer_r <= 8'd0;
      dir_r   <= 1'b0;
      g_one_r <= 1'b0;
      g_two_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      occ_r   <= 4'd0;
    end else if (!ena) begin
      // Frozen: everything holds, except that a done pulse is never stretched.
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            state_r            <= S_PH1;
            timer_r            <= 8'd0;
            dir_r              <= bus.cmd_dir;
            {g_one_r, g_two_r} <= gates(S_PH1, bus.cmd_dir);
            busy_r             <= 1'b1;
            if (!bus.cmd_dir) begin
              occ_r <= occ_r + 4'd1;
            end
          end
        end
        S_PH1: begin
          if (phase_end_s) begin
            state_r            <= S_PH2;
            timer_r            <= 8'd0;
            {g_one_r, g_two_r} <= gates(S_PH2, dir_r);
          end else begin
            timer_r <= timer_r + 8'd1;
          end
        end
        S_PH2: begin
          if (phase_end_s) begin
            state_r            <= S_PH3;
            timer_r            <= 8'd0;
            {g_one_r, g_two_r} <= gates(S_PH3, dir_r);
          end else begin
            timer_r <= timer_r + 8'd1;
          end
        end
        S_PH3: begin
          if (phase_end_s) begin
            state_r            <= S_GAP;
            timer_r            <= 8'd0;
            {g_one_r, g_two_r} <= 2'b00;
            done_r             <= (GAP_LAST == 8'd0);
            if (dir_r) begin
              occ_r <= occ_r - 4'd1;
            end
          end else begin
            timer_r <= timer_r + 8'd1;
          end
        end
        S_GAP: begin
          if (phase_end_s) begin
            state_r <= S_IDLE;
            timer_r <= 8'd0;
            busy_r  <= 1'b0;
          end else begin
            timer_r <= timer_r + 8'd1;
            done_r  <= ((timer_r + 8'd1) == GAP_LAST);
          end
        end
        default: begin
          state_r            <= S_IDLE;
          timer_r            <= 8'd0;
          {g_one_r, g_two_r} <= 2'b00;
          busy_r             <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = ena & (state_r == S_IDLE);
  assign bus.g_one     = g_one_r;
  assign bus.g_two     = g_two_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.occupancy = occ_r;

endmodule

// File: tb/tb_lion_gate_emitter.sv
// Directed bench for lion_gate_emitter: table-driven enter sequence plus hand-written
// multi-cycle cases, with a small lion-cage counter model fed from the gate outputs.
module tb_lion_gate_emitter;
  localparam int DWELL = 4;
  localparam int GAP   = 4;

  logic clk = 1'b0;
  logic reset;
  logic ena;

  lion_gate_emitter_if bus ();

  lion_gate_emitter #(.DWELL(DWELL), .GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] cnt_model;
  logic       pg1;
  logic       pg2;

  typedef struct {
    logic       g1;
    logic       g2;
    logic       busy;
    logic       done;
    logic       ready;
    logic [3:0] occ;
  } row_t;

  row_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: sample after the edge, check single-gate changes, update the counter model.
  task automatic tick();
    @(negedge clk);
    if (reset) begin
      cnt_model = 4'd0;
    end else begin
      if ((bus.g_one !== pg1) || (bus.g_two !== pg2)) begin
        check("gate_single_change",
              {31'd0, (bus.g_one !== pg1) && (bus.g_two !== pg2)}, 32'd0);
      end
      if (bus.g_one && !pg1 && !bus.g_two) begin
        cnt_model = cnt_model + 4'd1;
      end else if (!bus.g_one && pg1 && !bus.g_two && !pg2) begin
        cnt_model = cnt_model - 4'd1;
      end
    end
    pg1 = bus.g_one;
    pg2 = bus.g_two;
  endtask

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    while (!bus.cmd_ready && guard < 100) begin
      tick();
      guard++;
    end
    check({tag, "_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  // Full command with ena=1; checks occupancy at accept, on GAP entry and at done.
  task automatic run_cmd(input logic dir, input logic [3:0] exp_occ, input string tag);
    int k;
    logic [3:0] start_occ;
    bit seen;
    wait_ready(tag);
    start_occ     = bus.occupancy;
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = dir;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = ~dir;
    check({tag, "_occ_accept"}, {28'd0, bus.occupancy}, {28'd0, dir ? start_occ : exp_occ});
    k    = 1;
    seen = 1'b0;
    while (!seen && k < 100) begin
      tick();
      k++;
      if (k == 3 * DWELL + 1) check({tag, "_occ_gap"}, {28'd0, bus.occupancy}, {28'd0, exp_occ});
      if (bus.done) seen = 1'b1;
    end
    check({tag, "_done_cycle"}, k, 3 * DWELL + GAP);
    check({tag, "_occ_done"}, {28'd0, bus.occupancy}, {28'd0, exp_occ});
    check({tag, "_counter"}, {28'd0, cnt_model}, {28'd0, bus.occupancy});
    tick();
  endtask

  initial begin
    int acc;
    int bad;
    int k;
    int g11;
    int done_k;
    int guard;

    // Enter with DWELL=4, GAP=4: cycle T+k after accept at edge T, from occupancy 0.
    //            g1    g2    busy  done  ready occ
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1};

    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b0;
    ena           = 1'b1;
    reset         = 1'b1;
    pg1           = 1'b0;
    pg2           = 1'b0;
    cnt_model     = 4'd0;
    repeat (3) tick();
    check("reset_outputs", {bus.g_one, bus.g_two, bus.busy, bus.done, bus.occupancy}, 32'd0);
    reset = 1'b0;
    tick();
    check("reset_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // Table-driven enter sequence; cmd_dir flips after accept and must be ignored.
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_dir   = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) tick();
      check($sformatf("enter_k%0d", i + 1),
            {23'd0, bus.g_one, bus.g_two, bus.busy, bus.done, bus.cmd_ready, bus.occupancy},
            {23'd0, tbl[i].g1, tbl[i].g2, tbl[i].busy, tbl[i].done, tbl[i].ready, tbl[i].occ});
    end
    check("enter_counter", {28'd0, cnt_model}, 32'd1);

    run_cmd(1'b1, 4'd0,  "exit");
    run_cmd(1'b1, 4'd15, "under");
    run_cmd(1'b0, 4'd0,  "over");
    for (int i = 1; i <= 16; i++) begin
      run_cmd(1'b0, 4'(i), $sformatf("enter%0d", i));
    end

    // cmd_valid held long enough for two full sequences but not a third accept.
    acc = 0;
    bad = 0;
    for (int c = 0; c < 34; c++) begin
      bus.cmd_dir   = bus.cmd_ready ? 1'b0 : 1'($urandom_range(0, 1));
      bus.cmd_valid = 1'b1;
      if (bus.cmd_ready) acc++;
      if (bus.cmd_ready && bus.busy) bad++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    guard = 0;
    while (bus.busy && guard < 100) begin
      tick();
      guard++;
    end
    check("hold_accepts", acc, 2);
    check("hold_ready_while_busy", bad, 0);
    check("hold_occ", {28'd0, bus.occupancy}, 32'd2);
    check("hold_counter", {28'd0, cnt_model}, 32'd2);

    // ena low for five edges during PH2 stretches PH2 and delays done by five cycles.
    wait_ready("ena");
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    k      = 1;
    g11    = 0;
    done_k = 0;
    while (done_k == 0 && k < 60) begin
      if ({bus.g_one, bus.g_two} == 2'b11) g11++;
      if (!ena) begin
        check($sformatf("ena_off_ready_k%0d", k), {31'd0, bus.cmd_ready}, 32'd0);
        check($sformatf("ena_off_g_k%0d", k), {30'd0, bus.g_one, bus.g_two}, 32'd3);
        check($sformatf("ena_off_done_k%0d", k), {31'd0, bus.done}, 32'd0);
      end
      if (bus.done) done_k = k;
      ena = !(k >= 6 && k <= 10);
      if (done_k == 0) begin
        tick();
        k++;
      end
    end
    ena = 1'b1;
    check("ena_ph2_len", g11, DWELL + 5);
    check("ena_done_cycle", done_k, 3 * DWELL + GAP + 5);
    check("ena_occ", {28'd0, bus.occupancy}, 32'd3);
    tick();

    // Reset during exit PH3 aborts immediately.
    wait_ready("rst");
    bus.cmd_valid = 1'b1;
    bus.cmd_dir   = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 2; i <= 2 * DWELL + 2; i++) tick();
    check("rst_exit_ph3_g", {30'd0, bus.g_one, bus.g_two}, 32'd2);
    reset = 1'b1;
    tick();
    check("rst_abort", {bus.g_one, bus.g_two, bus.busy, bus.done, bus.occupancy}, 32'd0);
    reset = 1'b0;
    tick();
    check("rst_release_ready", {31'd0, bus.cmd_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
